// File: rtl/vga_timing_rx_if.sv
// Sampled VGA sync inputs and recovered timing outputs of vga_timing_rx.
interface vga_timing_rx_if #(
    parameter int unsigned CNT_BIT = 10
);
    logic               i_px_clk;
    logic               i_vga_hsync;
    logic               i_vga_vsync;
    logic               o_locked;
    logic               o_de;
    logic [CNT_BIT-1:0] o_x;
    logic [CNT_BIT-1:0] o_y;
    logic               o_frame_start;
    logic [CNT_BIT-1:0] o_h_period;
    logic [CNT_BIT-1:0] o_h_width;

    modport master (
        output i_px_clk, i_vga_hsync, i_vga_vsync,
        input  o_locked, o_de, o_x, o_y, o_frame_start, o_h_period, o_h_width
    );

    modport slave (
        input  i_px_clk, i_vga_hsync, i_vga_vsync,
        output o_locked, o_de, o_x, o_y, o_frame_start, o_h_period, o_h_width
    );
endinterface

// File: rtl/vga_timing_rx.sv
// VGA sync receiver: measures hsync period/width, locks on matching lines and
// rebuilds the active-video strobe and pixel coordinates.
module vga_timing_rx #(
    parameter int unsigned H_TOTAL    = 800,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned CNT_BIT    = 10,
    parameter int unsigned LOCK_LINES = 4
) (
    input logic            clk,
    input logic            i_sclr,
    vga_timing_rx_if.slave bus_io
);
    localparam logic [CNT_BIT-1:0] CntMax   = '1;
    localparam logic [CNT_BIT-1:0] HTotal   = CNT_BIT'(H_TOTAL);
    localparam logic [CNT_BIT-1:0] HSync    = CNT_BIT'(H_SYNC);
    localparam logic [CNT_BIT-1:0] HDeStart = CNT_BIT'(H_SYNC + H_BP);
    localparam logic [CNT_BIT-1:0] HDeEnd   = CNT_BIT'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CNT_BIT-1:0] VDeStart = CNT_BIT'(V_SYNC + V_BP);
    localparam logic [CNT_BIT-1:0] VDeEnd   = CNT_BIT'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [3:0]         LockCnt  = 4'(LOCK_LINES);

    typedef enum logic [1:0] {StSearch, StTrack, StLocked} state_e;

    state_e             state_q, state_d;
    logic [3:0]         good_cnt_q, good_cnt_d;
    logic               hs_prev_q, vs_prev_q;
    logic [CNT_BIT-1:0] hcnt_q, hcnt_d;
    logic [CNT_BIT-1:0] vcnt_q, vcnt_d;
    logic [CNT_BIT-1:0] h_period_q, h_period_d;
    logic [CNT_BIT-1:0] h_width_q, h_width_d;
    logic               frame_start_q, frame_start_d;

    logic               en, hs_rise, hs_fall, vs_rise;
    logic               hcnt_sat, line_good, locked;
    logic [CNT_BIT-1:0] hcnt_inc;
    logic               de;
    logic [CNT_BIT-1:0] x, y;

    assign en        = bus_io.i_px_clk;
    assign hs_rise   = en & bus_io.i_vga_hsync & ~hs_prev_q;
    assign hs_fall   = en & ~bus_io.i_vga_hsync & hs_prev_q;
    assign vs_rise   = en & bus_io.i_vga_vsync & ~vs_prev_q;
    assign hcnt_inc  = hcnt_q + CNT_BIT'(1);
    assign hcnt_sat  = (hcnt_q == CntMax);
    assign line_good = (hcnt_inc == HTotal) && (h_width_q == HSync);

    always_ff @(posedge clk) begin
        if (i_sclr) begin
            state_q    <= StSearch;
            good_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            good_cnt_q <= good_cnt_d;
        end
    end

    // A rise takes priority over saturation: it restarts the line count anyway.
    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        if (hs_rise) begin
            unique case (state_q)
                StSearch: begin
                    state_d    = StTrack;
                    good_cnt_d = '0;
                end
                StTrack: begin
                    if (line_good) begin
                        good_cnt_d = good_cnt_q + 4'd1;
                        if (good_cnt_q + 4'd1 == LockCnt) begin
                            state_d = StLocked;
                        end
                    end else begin
                        good_cnt_d = '0;
                    end
                end
                StLocked: begin
                    if (!line_good) begin
                        state_d    = StTrack;
                        good_cnt_d = '0;
                    end
                end
                default: state_d = StSearch;
            endcase
        end else if (en && hcnt_sat) begin
            state_d    = StSearch;
            good_cnt_d = '0;
        end
    end

    always_comb begin
        locked = (state_q == StLocked);
    end

    always_comb begin
        hcnt_d     = hcnt_q;
        vcnt_d     = vcnt_q;
        h_period_d = h_period_q;
        h_width_d  = h_width_q;
        if (en) begin
            if (hs_rise) begin
                hcnt_d = '0;
            end else if (!hcnt_sat) begin
                hcnt_d = hcnt_inc;
            end
            if (hs_fall) begin
                h_width_d = hcnt_inc;
            end
            if (hs_rise && state_q != StSearch) begin
                h_period_d = hcnt_inc;
            end
            if (vs_rise) begin
                vcnt_d = '0;
            end else if (hs_rise && vcnt_q != CntMax) begin
                vcnt_d = vcnt_q + CNT_BIT'(1);
            end
        end
    end

    assign frame_start_d = vs_rise & locked;

    // Sync history resets high so a line already in its pulse is not taken as an edge.
    always_ff @(posedge clk) begin
        if (i_sclr) begin
            hs_prev_q     <= 1'b1;
            vs_prev_q     <= 1'b1;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            h_period_q    <= '0;
            h_width_q     <= '0;
            frame_start_q <= 1'b0;
        end else begin
            if (en) begin
                hs_prev_q <= bus_io.i_vga_hsync;
                vs_prev_q <= bus_io.i_vga_vsync;
            end
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            h_period_q    <= h_period_d;
            h_width_q     <= h_width_d;
            frame_start_q <= frame_start_d;
        end
    end

    always_comb begin
        de = locked && (hcnt_q >= HDeStart) && (hcnt_q < HDeEnd) &&
             (vcnt_q >= VDeStart) && (vcnt_q < VDeEnd);
        x  = de ? hcnt_q - HDeStart : '0;
        y  = de ? vcnt_q - VDeStart : '0;
    end

    assign bus_io.o_locked      = locked;
    assign bus_io.o_de          = de;
    assign bus_io.o_x           = x;
    assign bus_io.o_y           = y;
    assign bus_io.o_frame_start = frame_start_q;
    assign bus_io.o_h_period    = h_period_q;
    assign bus_io.o_h_width     = h_width_q;
endmodule

// File: tb/tb_vga_timing_rx.sv
// Self-checking bench for vga_timing_rx: sync patterns with random enable gaps,
// compared against a line-level model of lock, measurement and frame position.
module tb_vga_timing_rx;
    logic clk;
    logic sclr;
    int   total;
    int   bad;

    vga_timing_rx_if #(.CNT_BIT(10)) vif ();

    vga_timing_rx dut (
        .clk    (clk),
        .i_sclr (sclr),
        .bus_io (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: position within line, line within frame, run of good lines.
    int         m_pos, m_vline, m_run;
    bit         m_hsp, m_vsp, m_acq, m_lk, m_fs, m_de;
    logic [9:0] m_ew, m_ep, m_x, m_y;

    task automatic model_reset();
        m_pos = 0; m_vline = 0; m_run = 0;
        m_hsp = 1'b1; m_vsp = 1'b1; m_acq = 1'b0; m_lk = 1'b0; m_fs = 1'b0; m_de = 1'b0;
        m_ew = '0; m_ep = '0; m_x = '0; m_y = '0;
    endtask

    task automatic tick(input bit hs, input bit vs, input int gap);
        bit rise, fall, vr;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        vif.i_px_clk    = 1'b1;
        vif.i_vga_hsync = hs;
        vif.i_vga_vsync = vs;
        @(posedge clk);
        #1;
        vif.i_px_clk = 1'b0;
        rise = hs && !m_hsp;
        fall = !hs && m_hsp;
        vr   = vs && !m_vsp;
        m_fs = vr && m_lk;
        if (fall) m_ew = 10'(m_pos + 1);
        if (rise) begin
            if (m_acq) begin
                m_ep = 10'(m_pos + 1);
                if (m_pos + 1 == 800 && m_ew == 10'd96) m_run++;
                else m_run = 0;
            end else begin
                m_acq = 1'b1;
                m_run = 0;
            end
        end else if (m_pos == 1023) begin
            m_acq = 1'b0;
            m_run = 0;
        end
        m_lk = m_acq && (m_run >= 4);
        if (vr) m_vline = 0;
        else if (rise && m_vline < 1023) m_vline++;
        if (rise) m_pos = 0;
        else if (m_pos < 1023) m_pos++;
        m_hsp = hs;
        m_vsp = vs;
        m_de = m_lk && m_pos >= 144 && m_pos < 784 && m_vline >= 35 && m_vline < 515;
        m_x  = m_de ? 10'(m_pos - 144) : 10'd0;
        m_y  = m_de ? 10'(m_vline - 35) : 10'd0;
    endtask

    task automatic test_reset();
        sclr = 1'b1;
        vif.i_px_clk = 1'b0; vif.i_vga_hsync = 1'b0; vif.i_vga_vsync = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        sclr = 1'b0;
        model_reset();
        total++; if (vif.o_locked !== 1'b0) begin bad++; $display("FAIL reset_locked: got %b want 0", vif.o_locked); end
        total++; if (vif.o_de !== 1'b0) begin bad++; $display("FAIL reset_de: got %b want 0", vif.o_de); end
        total++; if (vif.o_x !== 10'd0) begin bad++; $display("FAIL reset_x: got %0d want 0", vif.o_x); end
        total++; if (vif.o_y !== 10'd0) begin bad++; $display("FAIL reset_y: got %0d want 0", vif.o_y); end
        total++; if (vif.o_frame_start !== 1'b0) begin bad++; $display("FAIL reset_fs: got %b want 0", vif.o_frame_start); end
        total++; if (vif.o_h_period !== 10'd0) begin bad++; $display("FAIL reset_period: got %0d want 0", vif.o_h_period); end
        total++; if (vif.o_h_width !== 10'd0) begin bad++; $display("FAIL reset_width: got %0d want 0", vif.o_h_width); end
    endtask

    task automatic test_lock();
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 3);
        for (int l = 0; l < 5; l++) begin
            for (int p = 0; p < 800; p++) begin
                tick(p < 96, 1'b0, 3);
                total++;
                if (vif.o_locked !== m_lk || vif.o_de !== m_de) begin
                    bad++;
                    $display("FAIL lock_acq: line %0d px %0d locked=%b de=%b want %b %b",
                             l, p, vif.o_locked, vif.o_de, m_lk, m_de);
                end
                if (p == 0) begin
                    total++;
                    if (vif.o_locked !== (l == 4)) begin
                        bad++;
                        $display("FAIL lock_5th_rise: rise %0d locked=%b want %b",
                                 l + 1, vif.o_locked, (l == 4));
                    end
                end
            end
        end
        total++; if (vif.o_h_period !== 10'd800) begin bad++; $display("FAIL lock_period: got %0d want 800", vif.o_h_period); end
        total++; if (vif.o_h_width !== 10'd96) begin bad++; $display("FAIL lock_width: got %0d want 96", vif.o_h_width); end
    endtask

    task automatic test_bad_period();
        for (int l = 0; l < 6; l++) begin
            for (int p = 0; p < ((l == 0) ? 799 : 800); p++) begin
                tick(p < 96, 1'b0, int'($urandom_range(0, 1)));
                total++;
                if (vif.o_locked !== m_lk || vif.o_h_period !== m_ep) begin
                    bad++;
                    $display("FAIL bad_period: line %0d px %0d locked=%b period=%0d want %b %0d",
                             l, p, vif.o_locked, vif.o_h_period, m_lk, m_ep);
                end
                if (p == 0 && l == 1) begin
                    total++;
                    if (vif.o_locked !== 1'b0 || vif.o_h_period !== 10'd799) begin
                        bad++;
                        $display("FAIL bad_period_drop: locked=%b period=%0d want 0 799",
                                 vif.o_locked, vif.o_h_period);
                    end
                end
                if (p == 0 && l == 5) begin
                    total++;
                    if (vif.o_locked !== 1'b1) begin
                        bad++;
                        $display("FAIL bad_period_relock: locked=%b want 1", vif.o_locked);
                    end
                end
            end
        end
    endtask

    task automatic test_frame();
        for (int l = 0; l < 36; l++) begin
            for (int p = 0; p < 800; p++) begin
                tick(p < 96, l < 2, 0);
                total++;
                if (vif.o_frame_start !== m_fs || vif.o_de !== m_de ||
                    vif.o_x !== m_x || vif.o_y !== m_y) begin
                    bad++;
                    $display("FAIL frame_pos: line %0d px %0d fs=%b de=%b x=%0d y=%0d want %b %b %0d %0d",
                             l, p, vif.o_frame_start, vif.o_de, vif.o_x, vif.o_y,
                             m_fs, m_de, m_x, m_y);
                end
                if (l == 0 && p == 0) begin
                    total++;
                    if (vif.o_frame_start !== 1'b1) begin
                        bad++;
                        $display("FAIL frame_start: got %b want 1", vif.o_frame_start);
                    end
                end
                if (l == 35 && p == 144) begin
                    total++;
                    if (vif.o_de !== 1'b1 || vif.o_x !== 10'd0 || vif.o_y !== 10'd0) begin
                        bad++;
                        $display("FAIL frame_first_px: de=%b x=%0d y=%0d want 1 0 0",
                                 vif.o_de, vif.o_x, vif.o_y);
                    end
                end
            end
        end
    endtask

    task automatic test_stuck_high();
        for (int i = 0; i < 1100; i++) begin
            tick(1'b1, 1'b0, 0);
            total++;
            if (vif.o_locked !== m_lk) begin
                bad++;
                $display("FAIL stuck_lock: sample %0d locked=%b want %b", i, vif.o_locked, m_lk);
            end
        end
        total++;
        if (vif.o_locked !== 1'b0 || vif.o_h_period !== 10'd800) begin
            bad++;
            $display("FAIL stuck_final: locked=%b period=%0d want 0 800",
                     vif.o_locked, vif.o_h_period);
        end
    endtask

    task automatic test_sclr();
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 0);
        for (int l = 0; l < 5; l++) begin
            for (int p = 0; p < ((l == 4) ? 401 : 800); p++) begin
                tick(p < 96, 1'b0, 0);
                total++;
                if (vif.o_locked !== m_lk) begin
                    bad++;
                    $display("FAIL sclr_relock: line %0d px %0d locked=%b want %b",
                             l, p, vif.o_locked, m_lk);
                end
            end
        end
        sclr = 1'b1;
        @(posedge clk);
        #1;
        sclr = 1'b0;
        model_reset();
        total++;
        if (vif.o_locked !== 1'b0 || vif.o_de !== 1'b0 || vif.o_h_period !== 10'd0 ||
            vif.o_h_width !== 10'd0 || vif.o_x !== 10'd0 || vif.o_frame_start !== 1'b0) begin
            bad++;
            $display("FAIL sclr_clear: locked=%b de=%b period=%0d width=%0d x=%0d fs=%b want all 0",
                     vif.o_locked, vif.o_de, vif.o_h_period, vif.o_h_width, vif.o_x,
                     vif.o_frame_start);
        end
    endtask

    task automatic test_width95();
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 0);
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 0);
        for (int l = 0; l < 6; l++) begin
            for (int p = 0; p < 800; p++) begin
                tick(p < 95, 1'b0, int'($urandom_range(0, 1)));
                total++;
                if (vif.o_locked !== m_lk || vif.o_h_period !== m_ep ||
                    vif.o_h_width !== m_ew) begin
                    bad++;
                    $display("FAIL width95: line %0d px %0d locked=%b period=%0d width=%0d want %b %0d %0d",
                             l, p, vif.o_locked, vif.o_h_period, vif.o_h_width, m_lk, m_ep, m_ew);
                end
                if (l == 0 && p == 0) begin
                    total++;
                    if (vif.o_h_period !== 10'd0) begin
                        bad++;
                        $display("FAIL sclr_no_spurious_rise: period=%0d want 0", vif.o_h_period);
                    end
                end
            end
        end
        total++;
        if (vif.o_locked !== 1'b0 || vif.o_h_width !== 10'd95 || vif.o_h_period !== 10'd800) begin
            bad++;
            $display("FAIL width95_final: locked=%b width=%0d period=%0d want 0 95 800",
                     vif.o_locked, vif.o_h_width, vif.o_h_period);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        model_reset();
        test_reset();
        test_lock();
        test_bad_period();
        test_frame();
        test_stuck_high();
        test_sclr();
        test_width95();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
